// File: rtl/delay_slot_scheduler.sv
// ---------------------------------------------------------------------------
// delay_slot_scheduler
//
// Shares one CBITS-wide delay counter among NREQ requesters. An idle
// scheduler picks the next requester round-robin (starting at ptr), latches
// its delay clamped to MAXD, counts from 0 up to that delay and then pulses
// done for the granted channel. Dropping the request mid-service aborts it
// without a done pulse; the round-robin pointer still moves past the channel.
//
// Ports
//   clk   in   1           clock, rising edge
//   rst   in   1           synchronous active-high reset
//   req   in   NREQ        level request per channel
//   dly   in   NREQ*CBITS  delay of channel i at [i*CBITS +: CBITS]
//   gnt   out  NREQ        one-hot grant, held while the channel is serviced
//   done  out  NREQ        one-cycle one-hot completion pulse
//   sig   out  1           one-cycle pulse, equal to |done
//   busy  out  1           scheduler not idle
//   err   out  1           counter above MAXD (never set in legal use)
//   flg   out  1           counter within MAXD
// All outputs are registered.
// ---------------------------------------------------------------------------
module delay_slot_scheduler #(
    parameter int NREQ  = 4,
    parameter int CBITS = 14,
    parameter int MAXD  = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  sig,
    output logic                  busy,
    output logic                  err,
    output logic                  flg
);

    localparam int PBITS = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [CBITS-1:0]  d_q, d_d;
    logic [PBITS-1:0]  ptr_q, ptr_d;
    logic [PBITS-1:0]  chan_q, chan_d;
    logic [NREQ-1:0]   gnt_d, done_d;
    logic              sig_d, busy_d, err_d, flg_d;

    // Round-robin pick and the clamped delay of the picked channel.
    logic              pick_valid;
    logic [PBITS-1:0]  pick;
    logic [PBITS-1:0]  idx;
    logic [CBITS-1:0]  dly_sel;
    logic [CBITS-1:0]  d_clamp;
    logic [PBITS-1:0]  ptr_adv;
    logic              req_held;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PBITS'((int'(ptr_q) + k) % NREQ);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        dly_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PBITS'(i)) begin
                dly_sel = dly[i*CBITS +: CBITS];
            end
        end
    end

    assign d_clamp  = (dly_sel > CBITS'(MAXD)) ? CBITS'(MAXD) : dly_sel;
    assign ptr_adv  = (chan_q == PBITS'(NREQ - 1)) ? '0 : chan_q + PBITS'(1);
    assign req_held = req[chan_q];

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        gnt_d   = gnt;
        done_d  = '0;
        sig_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    chan_d  = pick;
                    d_d     = d_clamp;
                    gnt_d   = NREQ'(1) << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = '0;
                if (!req_held) begin
                    gnt_d   = '0;
                    ptr_d   = ptr_adv;
                    state_d = IDLE;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // A dropped request wins over a completion on the same edge.
                if (!req_held) begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    ptr_d   = ptr_adv;
                    state_d = IDLE;
                end else if (cnt_q >= d_q) begin
                    done_d  = gnt;
                    sig_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                gnt_d   = '0;
                ptr_d   = ptr_adv;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // Bound checks look at the counter value being registered this edge.
        err_d  = (cnt_d > CBITS'(MAXD));
        flg_d  = !err_d;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            ptr_q   <= '0;
            chan_q  <= '0;
            gnt     <= '0;
            done    <= '0;
            sig     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            flg     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            gnt     <= gnt_d;
            done    <= done_d;
            sig     <= sig_d;
            busy    <= busy_d;
            err     <= err_d;
            flg     <= flg_d;
        end
    end

endmodule

// File: tb/tb_delay_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_slot_scheduler
//
// Self-checking bench for delay_slot_scheduler: a table of single-request
// vectors, hand-written sequences for round-robin order, abort and reset, and
// a randomized run compared cycle by cycle against a timeline model.
// ---------------------------------------------------------------------------
module tb_delay_slot_scheduler;

    localparam int NREQ  = 4;
    localparam int CBITS = 14;
    localparam int MAXD  = 10000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] dly;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  sig;
    logic                  busy;
    logic                  err;
    logic                  flg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    delay_slot_scheduler #(
        .NREQ (NREQ),
        .CBITS(CBITS),
        .MAXD (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .dly (dly),
        .gnt (gnt),
        .done(done),
        .sig (sig),
        .busy(busy),
        .err (err),
        .flg (flg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string           name;
        logic [NREQ-1:0] req;
        logic [NREQ*CBITS-1:0] dly;
        int              exp_chan;
        int              exp_lat;   // edges from grant to done
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int ch);
        logic [NREQ-1:0] one;
        one = 1;
        return one << ch;
    endfunction

    function automatic logic [11:0] outs();
        return {gnt, done, sig, busy, err, flg};
    endfunction

    localparam logic [11:0] RESET_OUTS = 12'b0000_0000_0001;

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_dly(input int ch, input int v);
        dly[ch*CBITS +: CBITS] = CBITS'(v);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int limit, output int n, output bit bad);
        n   = 0;
        bad = 1'b0;
        while (done == 0 && n < limit) begin
            @(negedge clk);
            n++;
            if (err !== 1'b0 || flg !== 1'b1) bad = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline reference model: a service granted at edge t0 with clamped
    // delay d may be aborted on edges t0+1 .. t0+2+d, pulses done after
    // edge t0+2+d and releases the grant on edge t0+3+d.
    // ------------------------------------------------------------------
    bit              m_active;
    int              m_chan, m_t0, m_d, m_ptr, m_edge;
    logic [NREQ-1:0] exp_gnt, exp_done;
    bit              exp_busy;

    task automatic model_edge();
        int k;
        int raw;
        m_edge++;
        exp_done = '0;
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (!m_active) begin
            if (req != 0) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (req[(m_ptr + j) % NREQ]) begin
                        m_chan = (m_ptr + j) % NREQ;
                        break;
                    end
                end
                raw      = int'(dly[m_chan*CBITS +: CBITS]);
                m_d      = (raw > MAXD) ? MAXD : raw;
                m_t0     = m_edge;
                m_active = 1'b1;
            end
        end else begin
            k = m_edge - m_t0;
            if (k <= 2 + m_d && !req[m_chan]) begin
                m_active = 1'b0;
                m_ptr    = (m_chan + 1) % NREQ;
            end else if (k == 2 + m_d) begin
                exp_done = onehot(m_chan);
            end else if (k == 3 + m_d) begin
                m_active = 1'b0;
                m_ptr    = (m_chan + 1) % NREQ;
            end
        end
        exp_gnt  = m_active ? onehot(m_chan) : '0;
        exp_busy = m_active;
    endtask

    initial begin
        int  n, lat, prev;
        bit  bad, seen;

        vecs[0] = '{"v_single_ch1", 4'b0010, {14'd0, 14'd0, 14'd5, 14'd0},     1, 7};
        vecs[1] = '{"v_zero_ch0",   4'b0001, {14'd0, 14'd0, 14'd0, 14'd0},     0, 2};
        vecs[2] = '{"v_one_ch3",    4'b1000, {14'd1, 14'd0, 14'd0, 14'd0},     3, 3};
        vecs[3] = '{"v_rr_pick",    4'b1010, {14'd9, 14'd0, 14'd2, 14'd0},     1, 4};
        vecs[4] = '{"v_clamp_ch2",  4'b0100, {14'd0, 14'd16383, 14'd0, 14'd0}, 2, MAXD + 2};

        rst = 1'b1;
        req = '0;
        dly = '0;
        @(negedge clk);

        // ---------------- table-driven single requests ----------------
        for (int v = 0; v < 5; v++) begin
            do_reset();
            check({vecs[v].name, "_reset"}, outs(), RESET_OUTS);
            dly = vecs[v].dly;
            req = vecs[v].req;
            wait_gnt(n);
            check({vecs[v].name, "_gnt_lat"}, n, 1);
            check({vecs[v].name, "_gnt"}, gnt, onehot(vecs[v].exp_chan));
            wait_done(MAXD + 20, lat, bad);
            check({vecs[v].name, "_done_lat"}, lat, vecs[v].exp_lat);
            check({vecs[v].name, "_done"}, {done, sig}, {onehot(vecs[v].exp_chan), 1'b1});
            check({vecs[v].name, "_bounds"}, bad, 0);
            req = '0;
            @(negedge clk);
            check({vecs[v].name, "_release"}, {gnt, done, sig, busy}, 10'b0);
        end

        // ---------------- round-robin with all channels requesting ----------------
        do_reset();
        for (int c = 0; c < NREQ; c++) set_dly(c, 3);
        req  = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_done(30, n, bad);
            check($sformatf("rr_done_%0d", i), done, onehot(i % NREQ));
            if (i > 0) check($sformatf("rr_spacing_%0d", i), cyc - prev, 3 + 4);
            prev = cyc;
            @(negedge clk);
        end

        // ---------------- abort by dropping the request ----------------
        do_reset();
        set_dly(1, 20);
        set_dly(2, 4);
        req = 4'b0010;
        wait_gnt(n);
        check("abort_gnt", gnt, 4'b0010);
        req  = 4'b0110;  // extra request is ignored while channel 1 is serviced
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != 0) seen = 1'b1;
        end
        req = 4'b0101;
        @(negedge clk);
        if (done != 0) seen = 1'b1;
        check("abort_gnt_drop", {gnt, busy}, 5'b0);
        check("abort_no_done", seen, 0);
        wait_gnt(n);
        check("abort_next_ch2", gnt, 4'b0100);

        // ---------------- reset in the middle of a count ----------------
        do_reset();
        for (int c = 0; c < NREQ; c++) set_dly(c, 2);
        req = 4'b0001;
        wait_done(30, n, bad);
        check("rst_pre_done", done, 4'b0001);
        req = '0;
        repeat (3) @(negedge clk);
        set_dly(1, 20);
        req = 4'b0011;
        wait_gnt(n);
        check("rst_pre_gnt_ch1", gnt, 4'b0010);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", outs(), RESET_OUTS);
        rst = 1'b0;
        wait_gnt(n);
        check("rst_rearb_ch0", gnt, 4'b0001);

        // ---------------- randomized run against the timeline model ----------------
        do_reset();
        m_active = 1'b0;
        m_ptr    = 0;
        m_edge   = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NREQ; c++) begin
                if ($urandom_range(0, 63) == 0) set_dly(c, $urandom_range(MAXD - 2, 16383));
                else                            set_dly(c, $urandom_range(0, 12));
            end
            req = NREQ'($urandom);
            if (m_active) req[m_chan] = ($urandom_range(0, 15) != 0);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("rand_%0d", i), outs(),
                  {exp_gnt, exp_done, |exp_done, exp_busy, 1'b0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
